// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared state encoding, control struct and constants for fetch.
// Revision : 1.0
// ============================================================================
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic stall;
    logic squash;
  } stage_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_skid_buf
// Purpose  : One-entry pc/instruction hold register used while decode stalls.
// Revision : 1.0
// ============================================================================
module fetch_unit_skid_buf
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [31:0]     o_instr
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch with one outstanding OBI request, decode hold
//            buffer and redirect handling with in-flight response discard.
// Revision : 1.0
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  stage_ctrl_t     fetch_ctrl_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            imem_stall_o,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [31:0]     if_instr_o
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_addr;
  logic            r_discard;

  logic            w_buf_valid;
  logic [XLEN-1:0] w_buf_pc;
  logic [31:0]     w_buf_instr;
  logic            w_held;
  logic            w_avail;
  logic            w_accept;
  logic            w_buf_load;
  logic            w_valid;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_redir_pc;
  logic [31:0]     w_instr_src;

  assign w_pc_next  = r_pc + XLEN'(4);
  assign w_redir_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

  assign w_held   = (r_state == HOLD) && w_buf_valid;
  assign w_avail  = w_held || ((r_state == WAIT) && imem_rvalid_i && !r_discard);
  assign w_accept = w_avail && !fetch_ctrl_i.stall && !redirect_i;
  assign w_buf_load = (r_state == WAIT) && w_avail && fetch_ctrl_i.stall && !redirect_i;

  // The accepting cycle issues the next fetch directly so a 1-cycle memory streams.
  assign imem_req_o   = (r_state == REQ) || w_accept;
  assign imem_addr_o  = (r_state == REQ) ? r_addr : w_pc_next;
  assign imem_stall_o = !w_avail;

  assign w_instr_src = w_held ? w_buf_instr : imem_rdata_i;
  assign w_valid     = w_avail && !fetch_ctrl_i.squash && !redirect_i;
  assign if_valid_o  = w_valid;
  assign if_pc_o     = w_held ? w_buf_pc : r_pc;
  assign if_instr_o  = w_valid ? w_instr_src : NOP_INSTR;

  fetch_unit_skid_buf #(
    .XLEN (XLEN)
  ) u_skid_buf (
    .clk     (clk_i),
    .rst     (rst_i),
    .i_load  (w_buf_load),
    .i_clear (redirect_i || w_accept),
    .i_pc    (r_pc),
    .i_instr (imem_rdata_i),
    .o_valid (w_buf_valid),
    .o_pc    (w_buf_pc),
    .o_instr (w_buf_instr)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_addr    <= RESET_PC;
      r_discard <= 1'b0;
    end else begin
      if (redirect_i) begin
        r_pc <= w_redir_pc;
      end else if (w_accept) begin
        r_pc <= w_pc_next;
      end

      case (r_state)
        IDLE: begin
          r_state <= REQ;
          r_addr  <= redirect_i ? w_redir_pc : r_pc;
        end
        REQ: begin
          // The pending address stays on the bus; its response is dropped later.
          if (redirect_i) r_discard <= 1'b1;
          if (imem_gnt_i) r_state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            if (redirect_i || r_discard) begin
              r_state   <= REQ;
              r_addr    <= redirect_i ? w_redir_pc : r_pc;
              r_discard <= 1'b0;
            end else if (fetch_ctrl_i.stall) begin
              r_state <= HOLD;
            end else begin
              r_state <= imem_gnt_i ? WAIT : REQ;
              r_addr  <= w_pc_next;
            end
          end else if (redirect_i) begin
            r_discard <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_i) begin
            r_state <= REQ;
            r_addr  <= w_redir_pc;
          end else if (!fetch_ctrl_i.stall) begin
            r_state <= imem_gnt_i ? WAIT : REQ;
            r_addr  <= w_pc_next;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  a_rvalid_needs_grant: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rvalid_i |-> (r_state == WAIT));

  a_single_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    (imem_req_o && (r_state == WAIT)) |-> imem_rvalid_i);

  a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (imem_req_o && !imem_gnt_i) |=> (imem_req_o && (imem_addr_o == $past(imem_addr_o))));

endmodule
`default_nettype wire
